// File: rtl/ysyx_25040111_lsu_pkg.sv
// ============================================================================
// Module  : ysyx_25040111_lsu_pkg
// Brief   : LSU state encoding, access-size codes and alignment helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_25040111_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_WB   = 2'd3
    } lsu_state_t;

    localparam logic [1:0] MASK_B = 2'b01;
    localparam logic [1:0] MASK_H = 2'b10;
    localparam logic [1:0] MASK_W = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] off);
        return ((mask == MASK_H) && off[0]) || ((mask == MASK_W) && (off != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25040111_lsu_align.sv
// ============================================================================
// Module  : ysyx_25040111_lsu_align
// Brief   : Store lane replication/strobe and load byte/half extraction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_25040111_lsu_align
    import ysyx_25040111_lsu_pkg::*;
(
    input  logic [1:0]  i_st_off,
    input  logic [1:0]  i_st_mask,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    input  logic [1:0]  i_ld_off,
    input  logic [1:0]  i_ld_mask,
    input  logic        i_ld_sign,
    input  logic [31:0] i_ld_raw,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_st_data;
        case (i_st_mask)
            MASK_B: begin
                o_wstrb = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            MASK_H: begin
                o_wstrb = 4'b0011 << i_st_off;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_ld_raw[7:0];
        case (i_ld_off)
            2'd1:    w_byte = i_ld_raw[15:8];
            2'd2:    w_byte = i_ld_raw[23:16];
            2'd3:    w_byte = i_ld_raw[31:24];
            default: w_byte = i_ld_raw[7:0];
        endcase
        w_half = i_ld_off[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
    end

    always_comb begin
        o_ld_data = i_ld_raw;
        case (i_ld_mask)
            MASK_B:  o_ld_data = {{24{i_ld_sign & w_byte[7]}}, w_byte};
            MASK_H:  o_ld_data = {{16{i_ld_sign & w_half[15]}}, w_half};
            default: o_ld_data = i_ld_raw;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_25040111_lsu.sv
// ============================================================================
// Module  : ysyx_25040111_lsu
// Brief   : Load/store unit: one transaction at a time, IDLE/REQ/RESP/WB.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_25040111_lsu
    import ysyx_25040111_lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,

    input  logic        abt_valid,
    output logic        abt_ready,
    input  logic        abt_men,
    input  logic        abt_write,
    input  logic [31:0] abt_addr,
    input  logic [31:0] abt_wdata,
    input  logic [1:0]  abt_mask,
    input  logic        abt_rsign,
    input  logic [4:0]  abt_ard,
    input  logic [31:0] abt_rd,
    input  logic        abt_gen,
    input  logic [11:0] abt_acsr,
    input  logic [31:0] abt_csr,
    input  logic        abt_sen,
    input  logic [31:0] abt_pc,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        mem_rsp_ready,

    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,

    output logic        abt_finish,
    output logic [4:0]  abt_frd,
    output logic [31:0] wb_pc,
    output logic        misalign
);

    lsu_state_t  r_state;

    logic        r_write;
    logic [1:0]  r_off;
    logic [1:0]  r_mask;
    logic        r_rsign;
    logic [4:0]  r_ard;
    logic [31:0] r_rd;
    logic        r_gen;
    logic [11:0] r_acsr;
    logic [31:0] r_csr;
    logic        r_sen;
    logic [31:0] r_pc;

    logic [31:0] r_mem_addr;
    logic        r_mem_wen;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic        r_gpr_wen;
    logic [4:0]  r_gpr_waddr;
    logic [31:0] r_gpr_wdata;
    logic        r_csr_wen;
    logic [11:0] r_csr_waddr;
    logic [31:0] r_csr_wdata;
    logic        r_finish;
    logic [4:0]  r_frd;
    logic [31:0] r_wb_pc;
    logic        r_misalign;

    logic        w_mis;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;

    assign w_mis = abt_men & is_misaligned(abt_mask, abt_addr[1:0]);

    ysyx_25040111_lsu_align u_align (
        .i_st_off  (abt_addr[1:0]),
        .i_st_mask (abt_mask),
        .i_st_data (abt_wdata),
        .o_wstrb   (w_st_wstrb),
        .o_wdata   (w_st_wdata),
        .i_ld_off  (r_off),
        .i_ld_mask (r_mask),
        .i_ld_sign (r_rsign),
        .i_ld_raw  (mem_rdata),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_off       <= 2'b00;
            r_mask      <= 2'b00;
            r_rsign     <= 1'b0;
            r_ard       <= 5'd0;
            r_rd        <= 32'd0;
            r_gen       <= 1'b0;
            r_acsr      <= 12'd0;
            r_csr       <= 32'd0;
            r_sen       <= 1'b0;
            r_pc        <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wen   <= 1'b0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_gpr_wen   <= 1'b0;
            r_gpr_waddr <= 5'd0;
            r_gpr_wdata <= 32'd0;
            r_csr_wen   <= 1'b0;
            r_csr_waddr <= 12'd0;
            r_csr_wdata <= 32'd0;
            r_finish    <= 1'b0;
            r_frd       <= 5'd0;
            r_wb_pc     <= 32'd0;
            r_misalign  <= 1'b0;
        end else begin
            // Writeback strobes are single-cycle pulses; only WB entry raises them.
            r_gpr_wen  <= 1'b0;
            r_csr_wen  <= 1'b0;
            r_finish   <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (abt_valid) begin
                        r_write <= abt_write;
                        r_off   <= abt_addr[1:0];
                        r_mask  <= abt_mask;
                        r_rsign <= abt_rsign;
                        r_ard   <= abt_ard;
                        r_rd    <= abt_rd;
                        r_gen   <= abt_gen;
                        r_acsr  <= abt_acsr;
                        r_csr   <= abt_csr;
                        r_sen   <= abt_sen;
                        r_pc    <= abt_pc;
                        if (abt_men && !w_mis) begin
                            r_mem_addr  <= {abt_addr[31:2], 2'b00};
                            r_mem_wen   <= abt_write;
                            r_mem_wdata <= w_st_wdata;
                            r_mem_wstrb <= w_st_wstrb;
                            r_state     <= ST_REQ;
                        end else begin
                            r_finish    <= 1'b1;
                            r_frd       <= abt_ard;
                            r_wb_pc     <= abt_pc;
                            r_misalign  <= w_mis;
                            r_gpr_wen   <= abt_gen & ~w_mis & (abt_ard != 5'd0)
                                           & ~(abt_men & abt_write);
                            r_gpr_waddr <= abt_ard;
                            r_gpr_wdata <= abt_rd;
                            r_csr_wen   <= abt_sen;
                            r_csr_waddr <= abt_acsr;
                            r_csr_wdata <= abt_csr;
                            r_state     <= ST_WB;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rsp_valid) begin
                        r_finish    <= 1'b1;
                        r_frd       <= r_ard;
                        r_wb_pc     <= r_pc;
                        r_gpr_wen   <= r_gen & ~r_write & (r_ard != 5'd0);
                        r_gpr_waddr <= r_ard;
                        r_gpr_wdata <= r_write ? r_rd : w_ld_data;
                        r_csr_wen   <= r_sen;
                        r_csr_waddr <= r_acsr;
                        r_csr_wdata <= r_csr;
                        r_state     <= ST_WB;
                    end
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign abt_ready     = (r_state == ST_IDLE);
    assign mem_req_valid = (r_state == ST_REQ);
    assign mem_rsp_ready = (r_state == ST_RESP);
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wstrb     = r_mem_wstrb;
    assign gpr_wen       = r_gpr_wen;
    assign gpr_waddr     = r_gpr_waddr;
    assign gpr_wdata     = r_gpr_wdata;
    assign csr_wen       = r_csr_wen;
    assign csr_waddr     = r_csr_waddr;
    assign csr_wdata     = r_csr_wdata;
    assign abt_finish    = r_finish;
    assign abt_frd       = r_frd;
    assign wb_pc         = r_wb_pc;
    assign misalign      = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040111_lsu.sv
// ============================================================================
// Module  : tb_ysyx_25040111_lsu
// Brief   : Directed vector table, reset corner sequence and random traffic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_25040111_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        abt_valid = 1'b0, abt_ready;
    logic        abt_men = 1'b0, abt_write = 1'b0, abt_rsign = 1'b0;
    logic [31:0] abt_addr = '0, abt_wdata = '0, abt_rd = '0, abt_csr = '0, abt_pc = '0;
    logic [1:0]  abt_mask = 2'b11;
    logic [4:0]  abt_ard = '0;
    logic        abt_gen = 1'b0, abt_sen = 1'b0;
    logic [11:0] abt_acsr = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid = 1'b0, mem_rsp_ready;
    logic [31:0] mem_rdata = '0;
    logic        gpr_wen, csr_wen, abt_finish, misalign;
    logic [4:0]  gpr_waddr, abt_frd;
    logic [31:0] gpr_wdata, csr_wdata, wb_pc;
    logic [11:0] csr_waddr;

    always #5 clock = ~clock;

    ysyx_25040111_lsu dut (
        .clock(clock), .reset(reset),
        .abt_valid(abt_valid), .abt_ready(abt_ready),
        .abt_men(abt_men), .abt_write(abt_write), .abt_addr(abt_addr),
        .abt_wdata(abt_wdata), .abt_mask(abt_mask), .abt_rsign(abt_rsign),
        .abt_ard(abt_ard), .abt_rd(abt_rd), .abt_gen(abt_gen),
        .abt_acsr(abt_acsr), .abt_csr(abt_csr), .abt_sen(abt_sen), .abt_pc(abt_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata), .mem_rsp_ready(mem_rsp_ready),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .abt_finish(abt_finish), .abt_frd(abt_frd), .wb_pc(wb_pc), .misalign(misalign)
    );

    typedef struct packed {
        logic        men;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mask;
        logic        rsign;
        logic [4:0]  ard;
        logic [31:0] rd;
        logic        gen;
        logic [11:0] acsr;
        logic [31:0] csr;
        logic        sen;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          req_dly;
        int          rsp_dly;
    } txn_t;

    typedef struct packed {
        logic        memop;
        logic        mis;
        logic        gwen;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        logic [31:0] maddr;
        logic [31:0] gdata;
    } exp_t;

    typedef struct packed {
        txn_t t;
        exp_t e;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: access rules computed arithmetically from size code and offset.
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int unsigned off, v;
        off      = int'(t.addr[1:0]);
        e.mis    = t.men && ((t.mask == 2'b10 && off % 2 != 0) || (t.mask == 2'b11 && off != 0));
        e.memop  = t.men && !e.mis;
        e.maddr  = t.addr - off;
        e.strb   = 4'hF;
        e.mwdata = t.wdata;
        if (t.mask == 2'b01) begin
            e.strb   = 4'(1 << off);
            e.mwdata = (t.wdata & 32'hFF) * 32'h01010101;
        end else if (t.mask == 2'b10) begin
            e.strb   = 4'(3 << off);
            e.mwdata = (t.wdata & 32'hFFFF) * 32'h00010001;
        end
        v = t.rdata;
        if (t.mask == 2'b01) begin
            v = (t.rdata >> (8 * off)) % 256;
            if (t.rsign && v >= 128) v = v + 32'hFFFFFF00;
        end else if (t.mask == 2'b10) begin
            v = (t.rdata >> (8 * off)) % 65536;
            if (t.rsign && v >= 32768) v = v + 32'hFFFF0000;
        end
        e.gwen  = t.gen && !e.mis && t.ard != 0 && !(t.men && t.write);
        e.gdata = (t.men && !t.write) ? v : t.rd;
        return e;
    endfunction

    task automatic drive(input txn_t t);
        abt_men   = t.men;   abt_write = t.write; abt_addr = t.addr;
        abt_wdata = t.wdata; abt_mask  = t.mask;  abt_rsign = t.rsign;
        abt_ard   = t.ard;   abt_rd    = t.rd;    abt_gen   = t.gen;
        abt_acsr  = t.acsr;  abt_csr   = t.csr;   abt_sen   = t.sen;
        abt_pc    = t.pc;
    endtask

    task automatic run_txn(input txn_t t, input exp_t e);
        chk("ready_before_accept", abt_ready, 1);
        drive(t);
        abt_valid = 1'b1;
        tick();
        abt_valid = 1'b0;
        abt_addr  = $urandom;
        abt_wdata = $urandom;
        if (e.memop) begin
            for (int i = 0; i <= t.req_dly; i++) begin
                chk("req_valid", mem_req_valid, 1);
                chk("req_addr", mem_addr, e.maddr);
                chk("req_wen", mem_wen, t.write);
                if (t.write) begin
                    chk("req_wdata", mem_wdata, e.mwdata);
                    chk("req_wstrb", mem_wstrb, e.strb);
                end
                chk("ready_busy_req", abt_ready, 0);
                mem_req_ready = (i == t.req_dly);
                tick();
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i <= t.rsp_dly; i++) begin
                chk("rsp_ready", mem_rsp_ready, 1);
                chk("req_valid_drop", mem_req_valid, 0);
                chk("finish_early", abt_finish, 0);
                mem_rsp_valid = (i == t.rsp_dly);
                mem_rdata     = (i == t.rsp_dly) ? t.rdata : $urandom;
                tick();
            end
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
        end else begin
            chk("no_req", mem_req_valid, 0);
        end
        chk("wb_finish", abt_finish, 1);
        chk("wb_frd", abt_frd, t.ard);
        chk("wb_pc", wb_pc, t.pc);
        chk("wb_misalign", misalign, e.mis);
        chk("wb_gpr_wen", gpr_wen, e.gwen);
        if (e.gwen) begin
            chk("wb_gpr_waddr", gpr_waddr, t.ard);
            chk("wb_gpr_wdata", gpr_wdata, e.gdata);
        end
        chk("wb_csr_wen", csr_wen, t.sen);
        if (t.sen) begin
            chk("wb_csr_waddr", csr_waddr, t.acsr);
            chk("wb_csr_wdata", csr_wdata, t.csr);
        end
        chk("ready_in_wb", abt_ready, 0);
        tick();
        chk("finish_drop", abt_finish, 0);
        chk("gpr_wen_drop", gpr_wen, 0);
        chk("ready_after_wb", abt_ready, 1);
    endtask

    function automatic txn_t base_txn();
        txn_t t;
        t         = '0;
        t.mask    = 2'b11;
        t.pc      = 32'h8000_0100;
        t.rdata   = 32'h8012_3456;
        return t;
    endfunction

    vec_t vecs[10];

    initial begin
        txn_t t;
        exp_t e;

        // Directed table: {transaction, hand-derived expectations}.
        for (int i = 0; i < 10; i++) begin
            vecs[i].t = base_txn();
            vecs[i].e = '0;
            vecs[i].t.pc = 32'h8000_0000 + 32'(i * 4);
        end
        vecs[0].t.rd = 32'h1234; vecs[0].t.ard = 5; vecs[0].t.gen = 1;
        vecs[0].e.gwen = 1; vecs[0].e.gdata = 32'h1234;

        vecs[1].t.men = 1; vecs[1].t.addr = 32'h8000_0003; vecs[1].t.mask = 2'b01;
        vecs[1].t.rsign = 1; vecs[1].t.ard = 7; vecs[1].t.gen = 1;
        vecs[1].e.memop = 1; vecs[1].e.maddr = 32'h8000_0000;
        vecs[1].e.gwen = 1; vecs[1].e.gdata = 32'hFFFF_FF80;

        vecs[2] = vecs[1]; vecs[2].t.rsign = 0; vecs[2].e.gdata = 32'h0000_0080;
        vecs[2].t.rsp_dly = 1;

        vecs[3].t.men = 1; vecs[3].t.write = 1; vecs[3].t.addr = 32'h8000_0002;
        vecs[3].t.mask = 2'b10; vecs[3].t.wdata = 32'h0000_ABCD; vecs[3].t.gen = 1;
        vecs[3].t.ard = 3; vecs[3].t.req_dly = 5;
        vecs[3].e.memop = 1; vecs[3].e.maddr = 32'h8000_0000;
        vecs[3].e.strb = 4'b1100; vecs[3].e.mwdata = 32'hABCD_ABCD;

        vecs[4].t.men = 1; vecs[4].t.addr = 32'h8000_0001; vecs[4].t.gen = 1;
        vecs[4].t.ard = 4; vecs[4].e.mis = 1;

        vecs[5].t.sen = 1; vecs[5].t.acsr = 12'h300; vecs[5].t.csr = 32'hDEAD_BEEF;
        vecs[5].t.gen = 1; vecs[5].t.ard = 0;

        vecs[6].t.men = 1; vecs[6].t.addr = 32'h8000_0002; vecs[6].t.mask = 2'b10;
        vecs[6].t.rsign = 1; vecs[6].t.rdata = 32'h8001_7FFF; vecs[6].t.gen = 1;
        vecs[6].t.ard = 9; vecs[6].e.memop = 1; vecs[6].e.maddr = 32'h8000_0000;
        vecs[6].e.gwen = 1; vecs[6].e.gdata = 32'hFFFF_8001;

        vecs[7].t.men = 1; vecs[7].t.write = 1; vecs[7].t.addr = 32'h8000_0001;
        vecs[7].t.mask = 2'b01; vecs[7].t.wdata = 32'h1234_56A5; vecs[7].t.rsp_dly = 2;
        vecs[7].e.memop = 1; vecs[7].e.maddr = 32'h8000_0000;
        vecs[7].e.strb = 4'b0010; vecs[7].e.mwdata = 32'hA5A5_A5A5;

        vecs[8].t.men = 1; vecs[8].t.write = 1; vecs[8].t.addr = 32'h8000_0104;
        vecs[8].t.wdata = 32'hCAFE_F00D; vecs[8].t.gen = 1; vecs[8].t.ard = 2;
        vecs[8].e.memop = 1; vecs[8].e.maddr = 32'h8000_0104;
        vecs[8].e.strb = 4'b1111; vecs[8].e.mwdata = 32'hCAFE_F00D;

        vecs[9].t.men = 1; vecs[9].t.write = 1; vecs[9].t.addr = 32'h8000_0003;
        vecs[9].t.mask = 2'b10; vecs[9].t.sen = 1; vecs[9].t.acsr = 12'h341;
        vecs[9].t.csr = 32'h0000_0042; vecs[9].e.mis = 1;

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_rsp_ready", mem_rsp_ready, 0);
        chk("rst_gpr_wen", gpr_wen, 0);
        chk("rst_csr_wen", csr_wen, 0);
        chk("rst_finish", abt_finish, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_gpr_wdata", gpr_wdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", abt_ready, 1);

        for (int i = 0; i < 10; i++) run_txn(vecs[i].t, vecs[i].e);

        // Reset while waiting for the response abandons the load.
        t = base_txn();
        t.men = 1; t.addr = 32'h8000_0010; t.gen = 1; t.ard = 6;
        drive(t);
        abt_valid = 1'b1;
        tick();
        abt_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("rstresp_in_resp", mem_rsp_ready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstresp_idle", abt_ready, 1);
        chk("rstresp_rsp_ready", mem_rsp_ready, 0);
        chk("rstresp_gpr_wdata", gpr_wdata, 0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1111_2222;
        tick();
        mem_rsp_valid = 1'b0;
        chk("late_rsp_finish", abt_finish, 0);
        chk("late_rsp_gpr_wen", gpr_wen, 0);
        chk("late_rsp_idle", abt_ready, 1);
        tick();
        chk("late_rsp_finish2", abt_finish, 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            t         = base_txn();
            t.men     = ($urandom_range(0, 3) != 0);
            t.write   = $urandom_range(0, 1) == 1;
            t.addr    = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            t.wdata   = $urandom;
            t.mask    = 2'($urandom_range(1, 3));
            t.rsign   = $urandom_range(0, 1) == 1;
            t.ard     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            t.rd      = $urandom;
            t.gen     = $urandom_range(0, 3) != 0;
            t.acsr    = 12'($urandom);
            t.csr     = $urandom;
            t.sen     = $urandom_range(0, 3) == 0;
            t.pc      = $urandom & 32'hFFFF_FFFC;
            t.rdata   = $urandom;
            t.req_dly = $urandom_range(0, 3);
            t.rsp_dly = $urandom_range(0, 3);
            e = model(t);
            run_txn(t, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
